// File: rtl/pipeline_debug_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debug_pkg                                                                |
// | Shared constants and FSM encoding for the pipeline debug unit.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package debug_pkg;

    localparam int DBG_DATA_WIDTH = 32;
    localparam int DBG_NUM_WORDS  = 5;
    localparam int FRAME_BYTES    = DBG_NUM_WORDS * DBG_DATA_WIDTH / 8;

    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_HALT  = 8'h48;
    localparam logic [7:0] CMD_DUMP  = 8'h44;
    localparam logic [7:0] CMD_CLEAR = 8'h43;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        STEP    = 3'd2,
        CLEAR   = 3'd3,
        CAPTURE = 3'd4,
        SEND    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_debug_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_debug_unit_if                                                   |
// | UART-side byte streams: receive strobe and transmit valid/ready.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pipeline_debug_unit_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_debug_unit_snapshot_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snapshot_serializer                                                      |
// | Holds a captured frame and streams it MSB-byte first over valid/ready.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module snapshot_serializer #(
    parameter int FRAME_BYTES = 20
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic                     load,
    input  wire logic [FRAME_BYTES*8-1:0] snapshot,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  wire logic                     tx_ready,
    output logic                          done
);

    localparam int                CNT_W = $clog2(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    logic [FRAME_BYTES*8-1:0] r_snap;
    logic [CNT_W-1:0]         r_count;
    logic                     r_valid;
    logic [7:0]               w_bytes [FRAME_BYTES];
    logic                     w_fire;

    assign w_fire = r_valid && tx_ready;

    // Byte 0 is the most significant byte of the first captured word.
    for (genvar i = 0; i < FRAME_BYTES; i++) begin : g_bytes
        assign w_bytes[i] = r_snap[(FRAME_BYTES-i)*8-1 -: 8];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_snap  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_snap  <= snapshot;
            r_count <= '0;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            if (r_count == LAST_IDX) begin
                r_valid <= 1'b0;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign tx_valid = r_valid;
    assign tx_data  = r_valid ? w_bytes[r_count] : 8'h00;
    assign done     = w_fire && (r_count == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/pipeline_debug_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_debug_unit                                                      |
// | Command-driven run/step/halt control and debug snapshot streaming.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_debug_unit
    import debug_pkg::*;
#(
    parameter int                    DATA_WIDTH = DBG_DATA_WIDTH,
    parameter int                    NUM_WORDS  = DBG_NUM_WORDS,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = '1
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    pipeline_debug_unit_if.master      uart,
    output logic                       pc_enable,
    output logic                       pc_reset,
    input  wire logic [DATA_WIDTH-1:0] dbg_pc_addr,
    input  wire logic [DATA_WIDTH-1:0] dbg_pc_instr,
    input  wire logic [DATA_WIDTH-1:0] dbg_reg_w_data,
    input  wire logic [DATA_WIDTH-1:0] dbg_reg_rt_data,
    input  wire logic [DATA_WIDTH-1:0] dbg_reg_rs_data,
    output logic                       running,
    output logic                       halted
);

    localparam int SNAP_BYTES = NUM_WORDS * DATA_WIDTH / 8;

    state_t                        r_state;
    state_t                        w_next;
    logic                          r_halted;
    logic                          w_load;
    logic                          w_done;
    logic                          w_halt_hit;
    logic [NUM_WORDS*DATA_WIDTH-1:0] w_snapshot;

    assign w_snapshot = {dbg_pc_addr, dbg_pc_instr, dbg_reg_w_data,
                         dbg_reg_rt_data, dbg_reg_rs_data};
    assign w_halt_hit = (dbg_pc_instr == HALT_INSTR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == RUN && w_halt_hit) begin
                r_halted <= 1'b1;
            end else if (r_state == CLEAR) begin
                r_halted <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        pc_enable = 1'b0;
        pc_reset  = 1'b0;
        running   = 1'b0;
        w_load    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (uart.rx_valid) begin
                    // A sticky halt blocks further execution until cleared.
                    if (uart.rx_data == CMD_RUN && !r_halted) begin
                        w_next = RUN;
                    end else if (uart.rx_data == CMD_STEP && !r_halted) begin
                        w_next = STEP;
                    end else if (uart.rx_data == CMD_DUMP) begin
                        w_next = CAPTURE;
                    end else if (uart.rx_data == CMD_CLEAR) begin
                        w_next = CLEAR;
                    end
                end
            end
            RUN: begin
                pc_enable = 1'b1;
                running   = 1'b1;
                if (w_halt_hit || (uart.rx_valid && uart.rx_data == CMD_HALT)) begin
                    w_next = CAPTURE;
                end
            end
            STEP: begin
                pc_enable = 1'b1;
                w_next    = CAPTURE;
            end
            CLEAR: begin
                pc_reset = 1'b1;
                w_next   = IDLE;
            end
            CAPTURE: begin
                w_load = 1'b1;
                w_next = SEND;
            end
            SEND: begin
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign halted = r_halted;

    snapshot_serializer #(
        .FRAME_BYTES (SNAP_BYTES)
    ) u_serializer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_load),
        .snapshot (w_snapshot),
        .tx_data  (uart.tx_data),
        .tx_valid (uart.tx_valid),
        .tx_ready (uart.tx_ready),
        .done     (w_done)
    );

endmodule
`default_nettype wire
